// File: rtl/redux_pkg.sv
// Shared definitions for the reduction LFSR family: width, feedback taps, rewind FSM states.
package redux_pkg;

    localparam int unsigned LFSR_W = 64;

    // Feedback taps of the forward reduction LFSR: out[0] = s[63]^s[62]^s[60]^s[59].
    localparam int unsigned TAP_A = 63;
    localparam int unsigned TAP_B = 62;
    localparam int unsigned TAP_C = 60;
    localparam int unsigned TAP_D = 59;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } rewind_state_e;

endpackage

// File: rtl/lfsr64_rewind.sv
// One stage of the inverse reduction LFSR: recovers the state that preceded state_i.
module lfsr64_rewind
    import redux_pkg::*;
(
    input  logic [LFSR_W-1:0] state_i,
    output logic [LFSR_W-1:0] prev_c
);

    // The forward step shifted everything up by one, so each tap index moves up by one here.
    always_comb begin
        prev_c                 = {1'b0, state_i[LFSR_W-1:1]};
        prev_c[LFSR_W-1]       = state_i[0] ^ state_i[TAP_B+1] ^ state_i[TAP_C+1] ^ state_i[TAP_D+1];
    end

endmodule

// File: rtl/redux_lfsr_rewind.sv
// Single-job engine that rewinds the reduction LFSR by STEPS stages per clock, in_count times.
module redux_lfsr_rewind
    import redux_pkg::*;
#(
    parameter int unsigned STEPS = 64,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LFSR_W-1:0] in_state,
    input  logic [CNT_W-1:0]  in_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LFSR_W-1:0] out_state,
    output logic              busy
);

    rewind_state_e     fsm_q, fsm_d;
    logic [LFSR_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              accept;

    logic [LFSR_W-1:0] chain [0:STEPS];

    assign chain[0] = state_q;

    for (genvar i = 0; i < STEPS; i++) begin : g_step
        lfsr64_rewind u_step (
            .state_i (chain[i]),
            .prev_c  (chain[i+1])
        );
    end

    // Ready is gated by rst so that reset wins over a simultaneous request.
    assign in_ready  = (fsm_q == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_state = state_q;
    assign busy      = busy_q;

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        remaining_d = remaining_q;
        case (fsm_q)
            IDLE: begin
                if (accept) begin
                    state_d     = in_state;
                    remaining_d = in_count;
                    fsm_d       = (in_count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                state_d     = chain[STEPS];
                remaining_d = remaining_q - CNT_W'(1);
                if (remaining_q == CNT_W'(1)) begin
                    fsm_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
        out_valid_d = (fsm_d == DONE);
        busy_d      = (fsm_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            remaining_q <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            remaining_q <= remaining_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_redux_lfsr_rewind.sv
// Directed bench for redux_lfsr_rewind: default 64-stage build plus a STEPS=1 build.
module tb_redux_lfsr_rewind;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid0, in_valid1;
    logic [63:0] in_state;
    logic [15:0] in_count;
    logic        out_ready;

    logic        in_ready0, out_valid0, busy0;
    logic [63:0] out_state0;
    logic        in_ready1, out_valid1, busy1;
    logic [63:0] out_state1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    redux_lfsr_rewind u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid0),
        .in_ready  (in_ready0),
        .in_state  (in_state),
        .in_count  (in_count),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .out_state (out_state0),
        .busy      (busy0)
    );

    redux_lfsr_rewind #(.STEPS(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_state  (in_state),
        .in_count  (in_count),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_state (out_state1),
        .busy      (busy1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Forward reduction model, n single stages.
    function automatic logic [63:0] fwd(input logic [63:0] s, input int n);
        logic [63:0] t;
        t = s;
        for (int k = 0; k < n; k++) begin
            t = {t[62:0], t[63] ^ t[62] ^ t[60] ^ t[59]};
        end
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one job; lat counts edges from the accepting edge until out_valid, rdy_hi counts in_ready highs while busy.
    task automatic job(input bit sel, input logic [63:0] st, input logic [15:0] cnt,
                       output logic [63:0] res, output int lat, output int rdy_hi);
        in_state  = st;
        in_count  = cnt;
        out_ready = 1'b0;
        check("ready_before_job", sel ? in_ready1 : in_ready0, 1'b1);
        if (sel) in_valid1 = 1'b1; else in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        in_count  = ~cnt;
        in_state  = ~st;
        lat    = 0;
        rdy_hi = 0;
        while (!(sel ? out_valid1 : out_valid0) && lat < 300) begin
            if (sel ? in_ready1 : in_ready0) rdy_hi++;
            tick();
            lat++;
        end
        res = sel ? out_state1 : out_state0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [63:0] res, first_res;
    int          lat, rdy_hi, unstable, vlost, early;

    initial begin
        rst = 1'b1; in_valid0 = 1'b0; in_valid1 = 1'b0;
        in_state = '0; in_count = '0; out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", in_ready0, 1'b0);
        check("rst_out_valid", out_valid0, 1'b0);
        check("rst_busy", busy0, 1'b0);
        check("rst_out_state", out_state0, 64'h0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready0, 1'b1);

        job(1'b0, fwd(64'h0123456789ABCDEF, 64), 16'd1, res, lat, rdy_hi);
        check("roundtrip_state", res, 64'h0123456789ABCDEF);
        check("roundtrip_lat", 64'(lat), 64'd1);

        job(1'b0, fwd(64'hDEADBEEFCAFEF00D, 5 * 64), 16'd5, res, lat, rdy_hi);
        check("multi_state", res, 64'hDEADBEEFCAFEF00D);
        check("multi_lat", 64'(lat), 64'd5);
        check("multi_ready_low", 64'(rdy_hi), 64'd0);

        job(1'b0, 64'h8000000000000001, 16'd0, res, lat, rdy_hi);
        check("zero_state", res, 64'h8000000000000001);
        check("zero_lat", 64'(lat), 64'd0);

        job(1'b0, fwd(64'h13579BDF2468ACE0, 3 * 64), 16'd3, res, lat, rdy_hi);
        check("three_state", res, 64'h13579BDF2468ACE0);

        job(1'b0, 64'h0, 16'd100, res, lat, rdy_hi);
        check("fixed_point_state", res, 64'h0);
        check("fixed_point_lat", 64'(lat), 64'd100);

        // Backpressure: first job held in DONE while a second request waits.
        in_state = fwd(64'hA5A5A5A5F00DBABE, 128); in_count = 16'd2; out_ready = 1'b0;
        in_valid0 = 1'b1;
        tick();
        in_state = 64'h1122334455667788; in_count = 16'd0;
        tick();
        tick();
        check("bp_valid", out_valid0, 1'b1);
        first_res = out_state0;
        check("bp_state", first_res, 64'hA5A5A5A5F00DBABE);
        unstable = 0; vlost = 0; rdy_hi = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (out_state0 !== first_res) unstable++;
            if (out_valid0 !== 1'b1) vlost++;
            if (in_ready0 !== 1'b0) rdy_hi++;
        end
        check("bp_state_stable", 64'(unstable), 64'd0);
        check("bp_valid_held", 64'(vlost), 64'd0);
        check("bp_not_accepted", 64'(rdy_hi), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_released_valid", out_valid0, 1'b0);
        check("bp_idle_ready", in_ready0, 1'b1);
        tick();
        in_valid0 = 1'b0;
        check("bp_second_valid", out_valid0, 1'b1);
        check("bp_second_state", out_state0, 64'h1122334455667788);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        job(1'b1, 64'h2, 16'd1, res, lat, rdy_hi);
        check("s1_two", res, 64'h1);
        job(1'b1, 64'h1, 16'd1, res, lat, rdy_hi);
        check("s1_one", res, 64'h8000000000000000);
        job(1'b1, fwd(64'h0123456789ABCDEF, 64), 16'd64, res, lat, rdy_hi);
        check("s1_roundtrip_state", res, 64'h0123456789ABCDEF);
        check("s1_roundtrip_lat", 64'(lat), 64'd64);

        // Reset mid-run aborts the job.
        in_state = 64'hFEDCBA9876543210; in_count = 16'd50;
        in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        early = 0;
        for (int c = 0; c < 19; c++) begin
            if (out_valid0) early++;
            tick();
        end
        check("abort_busy_before", busy0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("abort_busy", busy0, 1'b0);
        check("abort_in_ready", in_ready0, 1'b1);
        check("abort_state_cleared", out_state0, 64'h0);
        for (int c = 0; c < 60; c++) begin
            if (out_valid0) early++;
            tick();
        end
        check("abort_no_valid", 64'(early), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
